serial_cmd_decoder: RTL and testbench

//  Decodes the 16-bit word stream from serial_rx into timing-board control events.

---
 rtl/serial_cmd_decoder_pkg.sv | 16 +
 rtl/serial_cmd_decoder_pulse_stretch.sv | 34 +++
 rtl/serial_cmd_decoder.sv | 187 ++++++++++++++++++
 tb/tb_serial_cmd_decoder.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/serial_cmd_decoder_pkg.sv
// rtl/serial_cmd_decoder_pkg.sv - sync-word values and FSM state encoding shared by rx decoder and tx encoder
// Purpose: single source for the command sync words and the decoder state encoding.
package serial_cmd_decoder_pkg;

    localparam logic [15:0] SYNC_ENCODE_ZERO = 16'hECDE;
    localparam logic [15:0] SYNC_ENCODE_POS  = 16'hECD1;
    localparam logic [15:0] SYNC_SCAN_BEGIN  = 16'h5A51;
    localparam logic [15:0] SYNC_SCAN_TEST   = 16'h5A53;
    localparam logic [15:0] SYNC_SCAN_END    = 16'h5A50;

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_PAYLOAD = 1'b1
    } state_t;

endpackage

// File: rtl/serial_cmd_decoder_pulse_stretch.sv
// rtl/serial_cmd_decoder_pulse_stretch.sv - retriggerable fixed-width pulse stretcher
// Purpose: pulse_o goes high on the edge after trig_i and stays high for WIDTH_CYC cycles;
//          a trigger while high reloads the count so the pulse extends without a gap.
// Ports:
//   clk_i    in  clock
//   rst_n_i  in  asynchronous reset, active low
//   trig_i   in  one-cycle trigger
//   pulse_o  out stretched pulse
module pulse_stretch #(
    parameter int WIDTH_CYC = 4
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic trig_i,
    output logic pulse_o
);

    localparam int CNT_W = $clog2(WIDTH_CYC + 1);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_cnt <= '0;
        end else if (trig_i) begin
            r_cnt <= CNT_W'(WIDTH_CYC);
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - CNT_W'(1);
        end
    end

    assign pulse_o = (r_cnt != '0);

endmodule

// File: rtl/serial_cmd_decoder.sv
// rtl/serial_cmd_decoder.sv - decodes the serial_rx word stream into timing-board control events
// Purpose: sync-word decoder with multi-word encoder-position frame, stretched zero pulse,
//          inter-word frame timeout and saturating error counters. 1-cycle output latency.
// Ports:
//   clk_i, rst_n_i       clock, asynchronous active-low reset
//   rx_valid_i/rx_data_i one-cycle word strobe and word
//   err_clr_i            synchronous clear of both error counters (wins over increment)
//   encode_zero_flag_o   stretched pulse on ENCODE_ZERO
//   pos_valid_o          one-cycle strobe when pos_data_o updates
//   pos_data_o           last complete encoder position, MSW first
//   scan_start_flag_o    scan active level
//   scan_test_flag_o     test scan active level
//   frame_busy_o         high while collecting a position payload
//   err_unknown_cnt_o    unrecognised words seen in IDLE
//   err_timeout_cnt_o    payload frames dropped on timeout
// PAYLOAD_WORDS must be >= 2; TIMEOUT_CYCLES >= 2; PULSE_WIDTH >= 1.
module serial_cmd_decoder
    import serial_cmd_decoder_pkg::*;
#(
    parameter int DATA_WIDTH     = 16,
    parameter int PAYLOAD_WORDS  = 2,
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int PULSE_WIDTH    = 4,
    parameter int ERR_CNT_WIDTH  = 16
) (
    input  logic                                clk_i,
    input  logic                                rst_n_i,
    input  logic                                rx_valid_i,
    input  logic [DATA_WIDTH-1:0]               rx_data_i,
    input  logic                                err_clr_i,
    output logic                                encode_zero_flag_o,
    output logic                                pos_valid_o,
    output logic [PAYLOAD_WORDS*DATA_WIDTH-1:0] pos_data_o,
    output logic                                scan_start_flag_o,
    output logic                                scan_test_flag_o,
    output logic                                frame_busy_o,
    output logic [ERR_CNT_WIDTH-1:0]            err_unknown_cnt_o,
    output logic [ERR_CNT_WIDTH-1:0]            err_timeout_cnt_o
);

    localparam int POS_W = PAYLOAD_WORDS * DATA_WIDTH;
    localparam int SHF_W = (PAYLOAD_WORDS - 1) * DATA_WIDTH;
    localparam int IDX_W = (PAYLOAD_WORDS > 1) ? $clog2(PAYLOAD_WORDS) : 1;
    localparam int TO_W  = $clog2(TIMEOUT_CYCLES);
    localparam logic [ERR_CNT_WIDTH-1:0] ERR_MAX = '1;

    state_t               r_state, w_state_nxt;
    logic [IDX_W-1:0]     r_idx;
    logic [TO_W-1:0]      r_to_cnt;
    logic [SHF_W-1:0]     r_shift;
    logic [POS_W-1:0]     r_pos_data;
    logic                 r_pos_valid;
    logic                 r_scan_start, r_scan_test;
    logic [ERR_CNT_WIDTH-1:0] r_err_unk, r_err_to;

    logic [POS_W-1:0]     w_assembled;
    logic                 w_zero_trig, w_pos_enter, w_word_in, w_frame_done;
    logic                 w_timeout, w_unknown, w_scan_wr, w_scan_start_val, w_scan_test_val;

    // Earlier words sit in r_shift; the incoming word completes the LSW.
    assign w_assembled = {r_shift, rx_data_i};

    always_comb begin
        w_state_nxt      = r_state;
        w_zero_trig      = 1'b0;
        w_pos_enter      = 1'b0;
        w_word_in        = 1'b0;
        w_frame_done     = 1'b0;
        w_timeout        = 1'b0;
        w_unknown        = 1'b0;
        w_scan_wr        = 1'b0;
        w_scan_start_val = 1'b0;
        w_scan_test_val  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (rx_valid_i) begin
                    if (rx_data_i == DATA_WIDTH'(SYNC_ENCODE_ZERO)) begin
                        w_zero_trig = 1'b1;
                    end else if (rx_data_i == DATA_WIDTH'(SYNC_ENCODE_POS)) begin
                        w_pos_enter = 1'b1;
                        w_state_nxt = ST_PAYLOAD;
                    end else if (rx_data_i == DATA_WIDTH'(SYNC_SCAN_BEGIN)) begin
                        w_scan_wr        = 1'b1;
                        w_scan_start_val = 1'b1;
                        w_scan_test_val  = r_scan_test;
                    end else if (rx_data_i == DATA_WIDTH'(SYNC_SCAN_TEST)) begin
                        w_scan_wr        = 1'b1;
                        w_scan_start_val = 1'b1;
                        w_scan_test_val  = 1'b1;
                    end else if (rx_data_i == DATA_WIDTH'(SYNC_SCAN_END)) begin
                        w_scan_wr = 1'b1;
                    end else begin
                        w_unknown = 1'b1;
                    end
                end
            end
            ST_PAYLOAD: begin
                // A word on the expiry cycle takes priority over the timeout.
                if (rx_valid_i) begin
                    w_word_in = 1'b1;
                    if (r_idx == IDX_W'(PAYLOAD_WORDS - 1)) begin
                        w_frame_done = 1'b1;
                        w_state_nxt  = ST_IDLE;
                    end
                end else if (r_to_cnt == TO_W'(TIMEOUT_CYCLES - 1)) begin
                    w_timeout   = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_idx        <= '0;
            r_to_cnt     <= '0;
            r_shift      <= '0;
            r_pos_data   <= '0;
            r_pos_valid  <= 1'b0;
            r_scan_start <= 1'b0;
            r_scan_test  <= 1'b0;
        end else begin
            r_pos_valid <= w_frame_done;
            if (w_frame_done) begin
                r_pos_data <= w_assembled;
            end
            if (w_pos_enter) begin
                r_idx    <= '0;
                r_to_cnt <= '0;
            end else if (w_word_in) begin
                r_idx    <= r_idx + IDX_W'(1);
                r_to_cnt <= '0;
                r_shift  <= w_assembled[SHF_W-1:0];
            end else if (r_state == ST_PAYLOAD) begin
                r_to_cnt <= r_to_cnt + TO_W'(1);
            end
            if (w_scan_wr) begin
                r_scan_start <= w_scan_start_val;
                r_scan_test  <= w_scan_test_val;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_err_unk <= '0;
            r_err_to  <= '0;
        end else if (err_clr_i) begin
            r_err_unk <= '0;
            r_err_to  <= '0;
        end else begin
            if (w_unknown && (r_err_unk != ERR_MAX)) begin
                r_err_unk <= r_err_unk + ERR_CNT_WIDTH'(1);
            end
            if (w_timeout && (r_err_to != ERR_MAX)) begin
                r_err_to <= r_err_to + ERR_CNT_WIDTH'(1);
            end
        end
    end

    pulse_stretch #(
        .WIDTH_CYC (PULSE_WIDTH)
    ) u_zero_stretch (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .trig_i  (w_zero_trig),
        .pulse_o (encode_zero_flag_o)
    );

    assign pos_valid_o       = r_pos_valid;
    assign pos_data_o        = r_pos_data;
    assign scan_start_flag_o = r_scan_start;
    assign scan_test_flag_o  = r_scan_test;
    assign frame_busy_o      = (r_state == ST_PAYLOAD);
    assign err_unknown_cnt_o = r_err_unk;
    assign err_timeout_cnt_o = r_err_to;

endmodule

// File: tb/tb_serial_cmd_decoder.sv
// tb/tb_serial_cmd_decoder.sv - self-checking bench for serial_cmd_decoder
module tb_serial_cmd_decoder;

    localparam int DW   = 16;
    localparam int PW   = 2;
    localparam int TO   = 1024;
    localparam int PLS  = 4;
    localparam int EW   = 4;
    localparam int EMAX = (1 << EW) - 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic rx_valid = 1'b0;
    logic [DW-1:0] rx_data = '0;
    logic err_clr = 1'b0;

    logic          zero_flag, pos_valid, scan_start, scan_test, busy;
    logic [PW*DW-1:0] pos_data;
    logic [EW-1:0] err_unk, err_to;

    int n_vec = 0;
    int n_miss = 0;

    serial_cmd_decoder #(
        .DATA_WIDTH     (DW),
        .PAYLOAD_WORDS  (PW),
        .TIMEOUT_CYCLES (TO),
        .PULSE_WIDTH    (PLS),
        .ERR_CNT_WIDTH  (EW)
    ) dut (
        .clk_i              (clk),
        .rst_n_i            (rst_n),
        .rx_valid_i         (rx_valid),
        .rx_data_i          (rx_data),
        .err_clr_i          (err_clr),
        .encode_zero_flag_o (zero_flag),
        .pos_valid_o        (pos_valid),
        .pos_data_o         (pos_data),
        .scan_start_flag_o  (scan_start),
        .scan_test_flag_o   (scan_test),
        .frame_busy_o       (busy),
        .err_unknown_cnt_o  (err_unk),
        .err_timeout_cnt_o  (err_to)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: frame collected in a queue, quiet-cycle count, pulse time left.
    bit            m_in_frame, m_start, m_test, m_pv;
    logic [DW-1:0] m_words[$];
    int            m_quiet, m_pulse, m_unk, m_to;
    logic [PW*DW-1:0] m_pos;
    bit            m_trig, m_inc_u, m_inc_t;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_in_frame = 0; m_start = 0; m_test = 0; m_pv = 0;
            m_words.delete();
            m_quiet = 0; m_pulse = 0; m_unk = 0; m_to = 0; m_pos = '0;
        end else begin
            m_trig = 0; m_inc_u = 0; m_inc_t = 0; m_pv = 0;
            if (m_in_frame) begin
                if (rx_valid) begin
                    m_words.push_back(rx_data);
                    m_quiet = 0;
                    if (m_words.size() == PW) begin
                        m_pos = '0;
                        foreach (m_words[i]) m_pos = (m_pos << DW) | (PW*DW)'(m_words[i]);
                        m_pv = 1;
                        m_in_frame = 0;
                    end
                end else begin
                    m_quiet++;
                    if (m_quiet == TO) begin
                        m_in_frame = 0;
                        m_inc_t = 1;
                    end
                end
            end else if (rx_valid) begin
                case (rx_data)
                    16'hECDE: m_trig = 1;
                    16'hECD1: begin m_in_frame = 1; m_words.delete(); m_quiet = 0; end
                    16'h5A51: m_start = 1;
                    16'h5A53: begin m_start = 1; m_test = 1; end
                    16'h5A50: begin m_start = 0; m_test = 0; end
                    default:  m_inc_u = 1;
                endcase
            end
            if (m_trig) m_pulse = PLS;
            else if (m_pulse > 0) m_pulse--;
            if (err_clr) begin
                m_unk = 0; m_to = 0;
            end else begin
                if (m_inc_u && m_unk < EMAX) m_unk++;
                if (m_inc_t && m_to < EMAX) m_to++;
            end
        end
    end

    always @(negedge clk) begin
        chk("m_zero_flag", zero_flag, m_pulse > 0);
        chk("m_pos_valid", pos_valid, m_pv);
        chk("m_pos_data", pos_data, m_pos);
        chk("m_scan_start", scan_start, m_start);
        chk("m_scan_test", scan_test, m_test);
        chk("m_busy", busy, m_in_frame);
        chk("m_err_unk", err_unk, m_unk);
        chk("m_err_to", err_to, m_to);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [DW-1:0] w);
        rx_valid = 1'b1;
        rx_data  = w;
        tick();
        rx_valid = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int cnt;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_pos_data", pos_data, 0);
        chk("rst_flags", {zero_flag, pos_valid, scan_start, scan_test, busy}, 0);
        chk("rst_counters", {err_unk, err_to}, 0);
        rst_n = 1'b1;
        tick();

        // 1: single zero pulse, then retrigger two cycles in
        send(16'hECDE);
        cnt = 0;
        repeat (10) begin cnt += int'(zero_flag); tick(); end
        chk("zero_width_single", cnt, 4);
        cnt = 0;
        send(16'hECDE);
        cnt += int'(zero_flag);
        tick();
        cnt += int'(zero_flag);
        send(16'hECDE);
        repeat (10) begin cnt += int'(zero_flag); tick(); end
        chk("zero_width_retrig", cnt, 6);

        // 2: position frame
        send(16'hECD1);
        chk("busy_in_frame", busy, 1);
        send(16'h1234);
        send(16'hABCD);
        chk("pos_valid_strobe", pos_valid, 1);
        chk("pos_data_1", pos_data, 32'h1234ABCD);
        chk("busy_after", busy, 0);
        tick();
        chk("pos_valid_one_cycle", pos_valid, 0);
        chk("pos_data_hold", pos_data, 32'h1234ABCD);

        // 3: sync values inside payload are data
        send(16'h5A51);
        send(16'hECD1);
        send(16'h5A50);
        send(16'hECDE);
        chk("pos_data_2", pos_data, 32'h5A50ECDE);
        chk("scan_unchanged", {scan_start, scan_test, zero_flag}, 3'b100);

        // 4: timeout boundary, then word-wins-on-expiry
        send(16'hECD1);
        send(16'h0001);
        repeat (TO - 1) tick();
        chk("to_not_yet", {busy, err_to}, {1'b1, 4'd0});
        tick();
        chk("to_expired", {busy, err_to}, {1'b0, 4'd1});
        send(16'hECDE);
        chk("zero_after_to", zero_flag, 1);
        send(16'hECD1);
        send(16'h0002);
        repeat (TO - 1) tick();
        send(16'h0003);
        chk("word_wins", {pos_valid, err_to}, {1'b1, 4'd1});
        chk("pos_data_3", pos_data, 32'h00020003);

        // 5: scan levels and unknown word
        send(16'h5A53);
        chk("scan_test_on", {scan_start, scan_test}, 2'b11);
        send(16'h5A51);
        chk("scan_begin_keep_test", {scan_start, scan_test}, 2'b11);
        send(16'h5A50);
        chk("scan_end", {scan_start, scan_test}, 2'b00);
        send(16'h5A50);
        chk("scan_end_idem", {scan_start, scan_test}, 2'b00);
        send(16'h1111);
        chk("err_unk_1", err_unk, 1);

        // 6: saturation, clear priority, reset mid-frame
        repeat (15) send(16'h1111);
        chk("err_unk_sat", err_unk, 15);
        err_clr = 1'b1;
        send(16'h2222);
        err_clr = 1'b0;
        chk("err_clr_wins", {err_unk, err_to}, 0);
        send(16'h5A51);
        send(16'hECD1);
        send(16'h1234);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_flags", {zero_flag, pos_valid, scan_start, scan_test, busy}, 0);
        chk("rst_mid_data", pos_data, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();
        send(16'hABCD);
        chk("after_rst_unknown", {err_unk, pos_valid, busy}, {4'd1, 1'b0, 1'b0});
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
